ahb_slave_mux: RTL

// - Parametrised AHB-Lite slave-to-master response multiplexer with built-in default slave.
// - Registers the decoder's HSEL one-hot vector during the address phase and uses it to route

---
 rtl/ahb_slave_mux_if.sv | 35 +++
 rtl/ahb_slave_mux.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ahb_slave_mux_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ahb_slave_mux_if                                            |
// | Purpose  : Bus bundle between decoder/slaves/master and the AHB-Lite   |
// |            response multiplexer.                                       |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface ahb_slave_mux_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 3,
  parameter int CNT_WIDTH  = 8
);
  logic [NUM_SLAVES-1:0]            HSEL;
  logic [1:0]                       HTRANS;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S;
  logic [NUM_SLAVES-1:0]            HRESP_S;
  logic [NUM_SLAVES-1:0]            HREADYOUT_S;
  logic [DATA_WIDTH-1:0]            HRDATA;
  logic                             HRESP;
  logic                             HREADY;
  logic [CNT_WIDTH-1:0]             ERR_COUNT;

  // Multiplexer side: consumes decode/slave signals, drives the master response.
  modport slave (
    input  HSEL, HTRANS, HRDATA_S, HRESP_S, HREADYOUT_S,
    output HRDATA, HRESP, HREADY, ERR_COUNT
  );

  // Environment side: decoder, slaves and master.
  modport master (
    output HSEL, HTRANS, HRDATA_S, HRESP_S, HREADYOUT_S,
    input  HRDATA, HRESP, HREADY, ERR_COUNT
  );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_mux.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : ahb_slave_mux                                               |
// | Purpose  : AHB-Lite slave-to-master response multiplexer with a        |
// |            built-in default slave that answers empty or ambiguous      |
// |            decodes with a two-cycle ERROR and counts them.             |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module ahb_slave_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ahb_slave_mux_if.slave  bus
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_err1 = 2'd1;
  localparam logic [1:0] c_err2 = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0] w_hsel_m1;
  logic                  w_hsel_onehot;
  logic [DATA_WIDTH-1:0] w_mux_data;
  logic                  w_mux_resp;
  logic                  w_mux_ready;
  logic [DATA_WIDTH-1:0] w_hrdata;
  logic                  w_hresp;
  logic                  w_hready;

  // A vector is one-hot when it is non-zero and clearing its lowest set bit leaves zero.
  assign w_hsel_m1     = bus.HSEL - NUM_SLAVES'(1);
  assign w_hsel_onehot = (bus.HSEL != '0) && ((bus.HSEL & w_hsel_m1) == '0);

  // AND-OR select of the slave chosen in the previous address phase; sel_q is one-hot or zero.
  always_comb begin
    w_mux_data  = '0;
    w_mux_resp  = 1'b0;
    w_mux_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        w_mux_data  = w_mux_data | bus.HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        w_mux_resp  = w_mux_resp | bus.HRESP_S[i];
        w_mux_ready = w_mux_ready | bus.HREADYOUT_S[i];
      end
    end
  end

  // Data-phase response: routed slave, zero-wait OKAY, or the two error cycles.
  always_comb begin
    w_hrdata = '0;
    w_hresp  = 1'b0;
    w_hready = 1'b1;
    case (state_q)
      c_idle: begin
        if (sel_q != '0) begin
          w_hrdata = w_mux_data;
          w_hresp  = w_mux_resp;
          w_hready = w_mux_ready;
        end
      end
      c_err1: begin
        w_hresp  = 1'b1;
        w_hready = 1'b0;
      end
      c_err2: begin
        w_hresp  = 1'b1;
        w_hready = 1'b1;
      end
      default: begin
        w_hrdata = '0;
        w_hresp  = 1'b0;
        w_hready = 1'b1;
      end
    endcase
  end

  assign bus.HRDATA    = w_hrdata;
  assign bus.HRESP     = w_hresp;
  assign bus.HREADY    = w_hready;
  assign bus.ERR_COUNT = cnt_q;

  // Address-phase capture while HREADY is high; ERR1 always advances to ERR2.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (state_q == c_err1) begin
      state_d = c_err2;
    end else if (w_hready) begin
      if (bus.HTRANS[1]) begin
        if (w_hsel_onehot) begin
          sel_d   = bus.HSEL;
          state_d = c_idle;
        end else begin
          sel_d   = '0;
          state_d = c_err1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end else begin
        sel_d   = '0;
        state_d = c_idle;
      end
    end
  end

  // State registers with asynchronous reset abandoning any transfer in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= c_idle;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire
